usb_hpi_master: RTL and testbench

Hardware initiator for the CY7C67200 EZ-OTG Host Port Interface (HPI). It replaces software bit-banging of the OTG data, address and strobe PIOs. Each Avalon-MM slave access from the Nios II becomes one timed HPI bus cycle: chip select, address setup, read/write strobe, data capture, then recovery. It sits between the system interconnect and the top-level tristate buffer on the OTG data pins.

---
 rtl/usb_hpi_master.sv | 190 +++++++++++++++++++
 tb/tb_usb_hpi_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_hpi_master.sv
// usb_hpi_master
// Avalon-MM slave that turns each Nios II access into one timed bus cycle
// on the CY7C67200 Host Port Interface. The sequence is: chip select with
// address setup, then the read or write strobe, then one hold cycle, then
// recovery with chip select released.
//
// Ports
//   clk, reset        : system clock, synchronous active-high reset
//   address[1:0]      : HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
//   chipselect, read,
//   write, writedata  : Avalon slave request
//   readdata          : data captured by the last completed HPI read
//   waitrequest       : Avalon stall (combinational)
//   otg_addr          : HPI address pins
//   otg_data_out/_oe  : HPI data bus drive value and tristate enable
//   otg_data_in       : HPI data bus as sampled from the pins
//   otg_cs_n, otg_rd_n, otg_wr_n : HPI chip select and strobes, active low
module usb_hpi_master #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_DONE,
        S_RECOVER
    } state_e;

    localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        oe_q, oe_d;

    logic req;

    assign req         = chipselect & (read | write);
    assign waitrequest = req & (state_q != S_DONE);

    // State register (together with the registered bus outputs).
    // NOTE: every sequential assignment is non-blocking so that all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= 2'd0;
            dout_q     <= 16'd0;
            rdata_q    <= 16'd0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rdata_q    <= rdata_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            oe_q       <= oe_d;
        end
    end

    // Next-state, counter and datapath capture.
    // NOTE: each variable gets a default before the case so that no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d     = address;
                    dout_d     = writedata;
                    is_write_d = write;   // read+write together is a write
                    cnt_d      = SETUP_LD;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Sample the bus on the edge that ends the strobe.
                    if (!is_write_q) begin
                        rdata_d = otg_data_in;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                cnt_d   = RECOVER_LD;
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus output decode.
    // NOTE: outputs are decoded from the next state and registered, so the
    // pins change on the same edge as the state and stay glitch-free.
    always_comb begin
        cs_n_d = 1'b1;
        rd_n_d = 1'b1;
        wr_n_d = 1'b1;
        oe_d   = 1'b0;
        case (state_d)
            S_SETUP: begin
                cs_n_d = 1'b0;
                oe_d   = is_write_d;
            end
            S_STROBE: begin
                cs_n_d = 1'b0;
                rd_n_d = is_write_d;
                wr_n_d = ~is_write_d;
                oe_d   = is_write_d;
            end
            S_DONE: begin
                // Strobe released, data still driven for write hold time.
                cs_n_d = 1'b0;
                oe_d   = is_write_d;
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    assign readdata     = rdata_q;
    assign otg_addr     = addr_q;
    assign otg_data_out = dout_q;
    assign otg_data_oe  = oe_q;
    assign otg_cs_n     = cs_n_q;
    assign otg_rd_n     = rd_n_q;
    assign otg_wr_n     = wr_n_q;

endmodule

// File: tb/tb_usb_hpi_master.sv
// Testbench for usb_hpi_master. Instance a uses the default timing,
// instance b uses SETUP=2, STROBE=1, RECOVER=1. Expected pin values are
// derived per cycle from the access timeline arithmetic.
module tb_usb_hpi_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] otg_data_in;
    logic        cs_a, cs_b;

    logic [15:0] rdata_a, rdata_b, dout_a, dout_b;
    logic [1:0]  oaddr_a, oaddr_b;
    logic        wait_a, wait_b, oe_a, oe_b;
    logic        csn_a, csn_b, rdn_a, rdn_b, wrn_a, wrn_b;

    always #10 clk = ~clk;

    usb_hpi_master u_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
        .read(read), .write(write), .writedata(writedata),
        .readdata(rdata_a), .waitrequest(wait_a), .otg_addr(oaddr_a),
        .otg_data_out(dout_a), .otg_data_oe(oe_a), .otg_data_in(otg_data_in),
        .otg_cs_n(csn_a), .otg_rd_n(rdn_a), .otg_wr_n(wrn_a)
    );

    usb_hpi_master #(
        .SETUP_CYCLES(2), .STROBE_CYCLES(1), .RECOVER_CYCLES(1)
    ) u_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
        .read(read), .write(write), .writedata(writedata),
        .readdata(rdata_b), .waitrequest(wait_b), .otg_addr(oaddr_b),
        .otg_data_out(dout_b), .otg_data_oe(oe_b), .otg_data_in(otg_data_in),
        .otg_cs_n(csn_b), .otg_rd_n(rdn_b), .otg_wr_n(wrn_b)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wd;
        logic [15:0] din;
    } cmd_t;

    cmd_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  m_addr[2];
    logic [15:0] m_dout[2];
    logic [15:0] m_rdata[2];

    function automatic cmd_t mk(logic rd, logic wr, logic [1:0] a,
                                logic [15:0] wd, logic [15:0] din);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.wd = wd; c.din = din;
        return c;
    endfunction

    function automatic int p_setup(int sel);   return (sel == 0) ? 1 : 2; endfunction
    function automatic int p_strobe(int sel);  return (sel == 0) ? 4 : 1; endfunction
    function automatic int p_recover(int sel); return (sel == 0) ? 2 : 1; endfunction

    task automatic chk(input string tag, input int k, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input cmd_t c);
        cs_a      = (sel == 0);
        cs_b      = (sel == 1);
        read      = c.rd;
        write     = c.wr;
        address   = c.addr;
        writedata = c.wd;
    endtask

    task automatic idle_bus();
        cs_a  = 1'b0;
        cs_b  = 1'b0;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_addr[i]  = 2'd0;
            m_dout[i]  = 16'd0;
            m_rdata[i] = 16'd0;
        end
    endtask

    // Runs every queued command on one instance, back to back, checking all
    // pins in every cycle from the accepting IDLE cycle to the last RECOVER.
    task automatic run_queue(input int sel);
        cmd_t c;
        int   s, t, r;
        bit   has_next, done;
        bit   in_cs, in_stb, rq;
        s = p_setup(sel);
        t = p_strobe(sel);
        r = p_recover(sel);
        c = q.pop_front();
        drive(sel, c);
        done = 1'b0;
        while (!done) begin
            has_next = (q.size() > 0);
            for (int k = 0; k <= s + t + r + 1; k++) begin
                if (k == s + t)     otg_data_in = c.din;
                else if (k > s + t) otg_data_in = 16'h0000;
                else                otg_data_in = 16'($urandom);
                @(negedge clk);
                in_cs  = (k >= 1) && (k <= s + t + 1);
                in_stb = (k >= s + 1) && (k <= s + t);
                rq     = (k <= s + t + 1) ? 1'b1 : has_next;
                chk("cs_n",  k, 16'(sel ? csn_b : csn_a), 16'(!in_cs));
                chk("rd_n",  k, 16'(sel ? rdn_b : rdn_a), 16'(!(in_stb && !c.wr)));
                chk("wr_n",  k, 16'(sel ? wrn_b : wrn_a), 16'(!(in_stb && c.wr)));
                chk("oe",    k, 16'(sel ? oe_b : oe_a),   16'(in_cs && c.wr));
                chk("waitrequest", k, 16'(sel ? wait_b : wait_a),
                    16'(rq && (k != s + t + 1)));
                chk("otg_addr", k, 16'(sel ? oaddr_b : oaddr_a),
                    16'((k >= 1) ? c.addr : m_addr[sel]));
                chk("otg_data_out", k, sel ? dout_b : dout_a,
                    (k >= 1) ? c.wd : m_dout[sel]);
                chk("readdata", k, sel ? rdata_b : rdata_a,
                    ((k >= s + t + 1) && !c.wr) ? c.din : m_rdata[sel]);
                @(posedge clk);
                #1;
                if (k == s + t + 1) begin
                    if (has_next) drive(sel, q[0]);
                    else          idle_bus();
                end
            end
            m_addr[sel] = c.addr;
            m_dout[sel] = c.wd;
            if (!c.wr) m_rdata[sel] = c.din;
            if (has_next) c = q.pop_front();
            else          done = 1'b1;
        end
    endtask

    initial begin
        cmd_t c;
        int   sel, nb, mode;

        // Reset with a request pending on both instances.
        reset       = 1'b1;
        cs_a        = 1'b1;
        cs_b        = 1'b1;
        read        = 1'b1;
        write       = 1'b0;
        address     = 2'd3;
        writedata   = 16'hFFFF;
        otg_data_in = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n_a", 0, 16'(csn_a), 16'd1);
        chk("rst_rd_n_a", 0, 16'(rdn_a), 16'd1);
        chk("rst_wr_n_a", 0, 16'(wrn_a), 16'd1);
        chk("rst_oe_a",   0, 16'(oe_a),  16'd0);
        chk("rst_readdata_a", 0, rdata_a, 16'd0);
        chk("rst_wait_a", 0, 16'(wait_a), 16'd1);
        chk("rst_cs_n_b", 0, 16'(csn_b), 16'd1);
        chk("rst_wait_b", 0, 16'(wait_b), 16'd1);
        chk("rst_readdata_b", 0, rdata_b, 16'd0);
        idle_bus();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed write, then read.
        q.push_back(mk(1'b0, 1'b1, 2'd2, 16'h1234, 16'h5555));
        run_queue(0);
        q.push_back(mk(1'b1, 1'b0, 2'd0, 16'hA5A5, 16'hBEEF));
        run_queue(0);

        // Back-to-back write then read with the request held.
        q.push_back(mk(1'b0, 1'b1, 2'd1, 16'hCAFE, 16'h0000));
        q.push_back(mk(1'b1, 1'b0, 2'd3, 16'h7777, 16'h1357));
        run_queue(0);

        // Reset asserted during cycle 3 of a write.
        c = mk(1'b0, 1'b1, 2'd1, 16'h0F0F, 16'h0000);
        drive(0, c);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_wr_n_before", 3, 16'(wrn_a), 16'd0);
        chk("mid_cs_n_before", 3, 16'(csn_a), 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_wr_n", 4, 16'(wrn_a), 16'd1);
        chk("mid_cs_n", 4, 16'(csn_a), 16'd1);
        chk("mid_oe",   4, 16'(oe_a),  16'd0);
        chk("mid_wait", 4, 16'(wait_a), 16'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        q.push_back(c);
        run_queue(0);

        // Short-timing instance: read followed by a held second access.
        q.push_back(mk(1'b1, 1'b0, 2'd2, 16'h0101, 16'h4242));
        q.push_back(mk(1'b0, 1'b1, 2'd0, 16'h9999, 16'h0000));
        run_queue(1);

        // Read and write together behaves as a write.
        q.push_back(mk(1'b1, 1'b1, 2'd1, 16'h3C3C, 16'hDEAD));
        run_queue(0);

        // Random accesses on both instances.
        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 1));
            nb  = int'($urandom_range(1, 3));
            for (int j = 0; j < nb; j++) begin
                mode = int'($urandom_range(0, 2));
                q.push_back(mk(mode != 1, mode != 0, 2'($urandom),
                               16'($urandom), 16'($urandom)));
            end
            run_queue(sel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
